// File: rtl/blake512_pkg.sv
// Shared constants, tables and helpers for the BLAKE-512 compression controller.
package blake512_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  // First 16 64-bit words of the fractional part of pi
  localparam logic [63:0] C64 [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  localparam int unsigned SIGMA [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  // (a,b,c,d) state indices: G0..G3 columns, G4..G7 diagonals
  localparam int unsigned GIDX [8][4] = '{
    '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
    '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
  };

  function automatic logic [63:0] h_word(input logic [511:0] x, input logic [2:0] i);
    return x[64*i +: 64];
  endfunction

  function automatic logic [63:0] m_word(input logic [1023:0] x, input logic [3:0] i);
    return x[64*i +: 64];
  endfunction

  function automatic logic [63:0] s_word(input logic [255:0] x, input logic [1:0] i);
    return x[64*i +: 64];
  endfunction

endpackage

// File: rtl/blake512_G_func.sv
// BLAKE-512 G function: purely combinational, one full G application per cycle.
module blake512_G_func (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [63:0] i_c,
  input  logic [63:0] i_d,
  input  logic [63:0] i_mj,
  input  logic [63:0] i_mk,
  input  logic [63:0] i_cj,
  input  logic [63:0] i_ck,
  output logic [63:0] o_a,
  output logic [63:0] o_b,
  output logic [63:0] o_c,
  output logic [63:0] o_d
);

  logic [63:0] w_a1, w_d1x, w_d1, w_c1, w_b1x, w_b1, w_d2x, w_b2x;

  // Right rotations by 32, 25, 16 and 11 are plain rewiring
  assign w_a1  = i_a + i_b + (i_mj ^ i_ck);
  assign w_d1x = i_d ^ w_a1;
  assign w_d1  = {w_d1x[31:0], w_d1x[63:32]};
  assign w_c1  = i_c + w_d1;
  assign w_b1x = i_b ^ w_c1;
  assign w_b1  = {w_b1x[24:0], w_b1x[63:25]};
  assign o_a   = w_a1 + w_b1 + (i_mk ^ i_cj);
  assign w_d2x = w_d1 ^ o_a;
  assign o_d   = {w_d2x[15:0], w_d2x[63:16]};
  assign o_c   = w_c1 + o_d;
  assign w_b2x = w_b1 ^ o_c;
  assign o_b   = {w_b2x[10:0], w_b2x[63:11]};

endmodule

// File: rtl/blake512_msg_sel.sv
// Selects the message words and constants feeding one G lane for a given round and G index.
module blake512_msg_sel
  import blake512_pkg::*;
(
  input  logic [1023:0] i_m,
  input  logic [3:0]    i_sidx,
  input  logic [2:0]    i_gidx,
  output logic [63:0]   o_mj,
  output logic [63:0]   o_mk,
  output logic [63:0]   o_cj,
  output logic [63:0]   o_ck
);

  logic [3:0] w_j, w_k;

  assign w_j  = 4'(SIGMA[i_sidx][{i_gidx, 1'b0}]);
  assign w_k  = 4'(SIGMA[i_sidx][{i_gidx, 1'b1}]);
  assign o_mj = m_word(i_m, w_j);
  assign o_mk = m_word(i_m, w_k);
  assign o_cj = C64[w_j];
  assign o_ck = C64[w_k];

endmodule

// File: rtl/blake512_compress_ctrl.sv
// BLAKE-512 compression sequencer: load, ROUNDS rounds on G_PAR shared G lanes, feed-forward.
// Optional salt support is enabled by defining BLAKE512_SALT_EN.
module blake512_compress_ctrl
  import blake512_pkg::*;
#(
  parameter int unsigned G_PAR  = 4,
  parameter int unsigned ROUNDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [511:0]  h_in,
  input  logic [1023:0] m_in,
  input  logic [127:0]  t_in,
`ifdef BLAKE512_SALT_EN
  input  logic [255:0]  salt_in,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [511:0]  h_out,
  output logic          busy
);

  localparam int unsigned STEPS = 8 / G_PAR;

  state_e         r_state;
  logic [2:0]     r_step;
  logic [3:0]     r_round;
  logic [3:0]     r_sidx;
  logic [63:0]    r_v [16];
  logic [511:0]   r_h;
  logic [1023:0]  r_m;
  logic [511:0]   r_h_out;
  logic           r_out_valid;
  logic           r_busy;
`ifdef BLAKE512_SALT_EN
  logic [255:0]   r_salt;
`endif

  logic [63:0]    w_v_load [16];
  logic [63:0]    w_v_g [16];
  logic [511:0]   w_h_fin;
  logic [3:0]     w_ia [G_PAR];
  logic [3:0]     w_ib [G_PAR];
  logic [3:0]     w_ic [G_PAR];
  logic [3:0]     w_id [G_PAR];
  logic [63:0]    w_na [G_PAR];
  logic [63:0]    w_nb [G_PAR];
  logic [63:0]    w_nc [G_PAR];
  logic [63:0]    w_nd [G_PAR];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign h_out     = r_h_out;
  assign busy      = r_busy;

  // Lane gi handles G index step*G_PAR+gi, so columns finish before diagonals start
  for (genvar gi = 0; gi < G_PAR; gi++) begin : g_lane
    logic [2:0]  w_g;
    logic [63:0] w_mj, w_mk, w_cj, w_ck;

    assign w_g     = 3'(32'(r_step) * G_PAR + gi);
    assign w_ia[gi] = 4'(GIDX[w_g][0]);
    assign w_ib[gi] = 4'(GIDX[w_g][1]);
    assign w_ic[gi] = 4'(GIDX[w_g][2]);
    assign w_id[gi] = 4'(GIDX[w_g][3]);

    blake512_msg_sel u_msg_sel (
      .i_m    (r_m),
      .i_sidx (r_sidx),
      .i_gidx (w_g),
      .o_mj   (w_mj),
      .o_mk   (w_mk),
      .o_cj   (w_cj),
      .o_ck   (w_ck)
    );

    blake512_G_func u_g (
      .i_a  (r_v[w_ia[gi]]),
      .i_b  (r_v[w_ib[gi]]),
      .i_c  (r_v[w_ic[gi]]),
      .i_d  (r_v[w_id[gi]]),
      .i_mj (w_mj),
      .i_mk (w_mk),
      .i_cj (w_cj),
      .i_ck (w_ck),
      .o_a  (w_na[gi]),
      .o_b  (w_nb[gi]),
      .o_c  (w_nc[gi]),
      .o_d  (w_nd[gi])
    );
  end

  // Initial state vector built straight from the inputs at accept
  always_comb begin
    for (int i = 0; i < 8; i++) w_v_load[i] = h_word(h_in, 3'(i));
`ifdef BLAKE512_SALT_EN
    for (int i = 0; i < 4; i++) w_v_load[8+i] = C64[i] ^ s_word(salt_in, 2'(i));
`else
    for (int i = 0; i < 4; i++) w_v_load[8+i] = C64[i];
`endif
    w_v_load[12] = C64[4] ^ t_in[63:0];
    w_v_load[13] = C64[5] ^ t_in[63:0];
    w_v_load[14] = C64[6] ^ t_in[127:64];
    w_v_load[15] = C64[7] ^ t_in[127:64];
  end

  // Write the lane results back over their (a,b,c,d) slots; lanes never overlap in one step
  always_comb begin
    w_v_g = r_v;
    for (int i = 0; i < G_PAR; i++) begin
      w_v_g[w_ia[i]] = w_na[i];
      w_v_g[w_ib[i]] = w_nb[i];
      w_v_g[w_ic[i]] = w_nc[i];
      w_v_g[w_id[i]] = w_nd[i];
    end
  end

  // Feed-forward into the new chain value
  always_comb begin
    w_h_fin = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef BLAKE512_SALT_EN
      w_h_fin[64*i +: 64] = h_word(r_h, 3'(i)) ^ r_v[i] ^ r_v[i+8] ^ s_word(r_salt, 2'(i % 4));
`else
      w_h_fin[64*i +: 64] = h_word(r_h, 3'(i)) ^ r_v[i] ^ r_v[i+8];
`endif
    end
  end

  // Control FSM with state vector, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_round     <= '0;
      r_sidx      <= '0;
      r_v         <= '{default: '0};
      r_h         <= '0;
      r_m         <= '0;
      r_h_out     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef BLAKE512_SALT_EN
      r_salt      <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_h     <= h_in;
            r_m     <= m_in;
            r_v     <= w_v_load;
            r_step  <= '0;
            r_round <= '0;
            r_sidx  <= '0;
            r_busy  <= 1'b1;
            r_state <= ROUND;
`ifdef BLAKE512_SALT_EN
            r_salt  <= salt_in;
`endif
          end
        end
        ROUND: begin
          r_v <= w_v_g;
          if (r_step == 3'(STEPS - 1)) begin
            r_step <= '0;
            if (r_round == 4'(ROUNDS - 1)) begin
              r_round <= '0;
              r_sidx  <= '0;
              r_state <= FINAL;
            end else begin
              r_round <= r_round + 4'd1;
              r_sidx  <= (r_sidx == 4'd9) ? 4'd0 : r_sidx + 4'd1;
            end
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        FINAL: begin
          r_h_out     <= w_h_fin;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake512_compress_ctrl.sv
// Scoreboard bench for blake512_compress_ctrl: three instances (G_PAR 4, 1, 2), one active at a time.
module tb_blake512_compress_ctrl;

  localparam logic [63:0] K [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };
  localparam logic [63:0] IV [8] = '{
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
  };
  localparam int SG [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };

  typedef struct {
    logic [511:0] h;
    int           lat;
    int           k;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ordy;
  logic [511:0]  hin;
  logic [1023:0] min;
  logic [127:0]  tin;
  logic [255:0]  salt = '0;
  logic          iv [3];
  logic          ir [3];
  logic          ov [3];
  logic          bz [3];
  logic [511:0]  ho [3];

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc [3];
  logic prev_ov [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  blake512_compress_ctrl #(.G_PAR(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .h_in(hin), .m_in(min),
    .t_in(tin),
`ifdef BLAKE512_SALT_EN
    .salt_in(salt),
`endif
    .out_valid(ov[0]), .out_ready(ordy), .h_out(ho[0]), .busy(bz[0])
  );
  blake512_compress_ctrl #(.G_PAR(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .h_in(hin), .m_in(min),
    .t_in(tin),
`ifdef BLAKE512_SALT_EN
    .salt_in(salt),
`endif
    .out_valid(ov[1]), .out_ready(ordy), .h_out(ho[1]), .busy(bz[1])
  );
  blake512_compress_ctrl #(.G_PAR(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .h_in(hin), .m_in(min),
    .t_in(tin),
`ifdef BLAKE512_SALT_EN
    .salt_in(salt),
`endif
    .out_valid(ov[2]), .out_ready(ordy), .h_out(ho[2]), .busy(bz[2])
  );

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Straight sequential BLAKE-512 compression (no salt)
  function automatic logic [511:0] model(logic [511:0] h, logic [1023:0] m, logic [127:0] t);
    logic [63:0]  v [16];
    logic [63:0]  mw [16];
    logic [511:0] r;
    int a, b, c, d, j, k, q;
    for (int i = 0; i < 16; i++) mw[i] = m[64*i +: 64];
    for (int i = 0; i < 8; i++) v[i] = h[64*i +: 64];
    for (int i = 0; i < 4; i++) v[8+i] = K[i];
    v[12] = K[4] ^ t[63:0];
    v[13] = K[5] ^ t[63:0];
    v[14] = K[6] ^ t[127:64];
    v[15] = K[7] ^ t[127:64];
    for (int rd = 0; rd < 16; rd++) begin
      for (int g = 0; g < 8; g++) begin
        if (g < 4) begin
          a = g; b = 4 + g; c = 8 + g; d = 12 + g;
        end else begin
          q = g - 4;
          a = q; b = 4 + (q + 1) % 4; c = 8 + (q + 2) % 4; d = 12 + (q + 3) % 4;
        end
        j = SG[rd % 10][2*g];
        k = SG[rd % 10][2*g+1];
        v[a] = v[a] + v[b] + (mw[j] ^ K[k]);
        v[d] = ror(v[d] ^ v[a], 32);
        v[c] = v[c] + v[d];
        v[b] = ror(v[b] ^ v[c], 25);
        v[a] = v[a] + v[b] + (mw[k] ^ K[j]);
        v[d] = ror(v[d] ^ v[a], 16);
        v[c] = v[c] + v[d];
        v[b] = ror(v[b] ^ v[c], 11);
      end
    end
    for (int i = 0; i < 8; i++) r[64*i +: 64] = h[64*i +: 64] ^ v[i] ^ v[i+8];
    return r;
  endfunction

  // Monitor: latency on out_valid rise, h_out against head every cycle it is valid
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) prev_ov[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (iv[k] && ir[k]) acc_cyc[k] = cyc + 1;
        if (ov[k]) begin
          if (sb_q.size() == 0) begin
            chk("spurious_out", {511'd0, ov[k]}, '0);
          end else begin
            chk("dut_sel", 512'(k), 512'(sb_q[0].k));
            if (!prev_ov[k]) chk("latency", 512'(cyc - acc_cyc[k]), 512'(sb_q[0].lat));
            chk("h_out", ho[k], sb_q[0].h);
            if (ordy) void'(sb_q.pop_front());
          end
        end
        prev_ov[k] = ov[k];
      end
    end
  end

  function automatic void push_exp(int k, logic [511:0] h, logic [1023:0] m, logic [127:0] t);
    exp_t e;
    e.h   = model(h, m, t);
    e.lat = (k == 0) ? 33 : (k == 1) ? 129 : 65;
    e.k   = k;
    sb_q.push_back(e);
  endfunction

  // Called #1 after an edge; returns #1 after the accept edge
  task automatic send(int k, logic [511:0] h, logic [1023:0] m, logic [127:0] t);
    int n = 0;
    hin = h; min = m; tin = t; iv[k] = 1'b1;
    push_exp(k, h, m, t);
    while (!ir[k] && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("accept_timeout", 512'(n), '0);
    @(posedge clk); #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 400) chk("drain_timeout", 512'(n), '0);
  endtask

  logic [511:0]  h_iv, h3;
  logic [1023:0] m1, m2, m3;
  logic [127:0]  t1, t2, t3;

  initial begin
    int n;
    rst = 1'b1; ordy = 1'b1; hin = '0; min = '0; tin = '0;
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; acc_cyc[k] = 0; end
    for (int i = 0; i < 8; i++) begin
      h_iv[64*i +: 64] = IV[i];
      h3[64*i +: 64]   = ~IV[i];
    end
    m1 = '0; m1[63:0] = 64'h8000000000000000; m1[64*13 +: 64] = 64'd1; t1 = '0;
    for (int i = 0; i < 16; i++) begin
      m2[64*i +: 64] = 64'(i);
      m3[64*i +: 64] = 64'h0123456789ABCDEF ^ (64'(i) * 64'h1111);
    end
    t2 = {64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    t3 = 128'd1024;

    // Reset state
    #12;
    chk("rst_in_ready", {511'd0, ir[0]}, 512'd1);
    chk("rst_out_valid", {511'd0, ov[0]}, 512'd0);
    chk("rst_busy", {511'd0, bz[0]}, 512'd0);
    chk("rst_h_out", ho[0], '0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // All-zero / empty-message block
    send(0, h_iv, m1, t1);
    chk("busy_after_accept", {511'd0, bz[0]}, 512'd1);
    chk("in_ready_busy", {511'd0, ir[0]}, 512'd0);
    drain();

    // Counter split and SIGMA reuse
    send(0, h_iv, m2, t2);
    drain();

    // Backpressure with ignored in_valid pulses, then back-to-back accept
    ordy = 1'b0;
    send(0, h3, m3, t3);
    n = 0;
    while (!ov[0] && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk("out_valid_timeout", 512'(n), '0);
    for (int c = 0; c < 20; c++) begin
      chk("bp_in_ready", {511'd0, ir[0]}, 512'd0);
      iv[0] = ~iv[0];
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    hin = h_iv; min = m1; tin = t1;
    push_exp(0, h_iv, m1, t1);
    iv[0] = 1'b1; ordy = 1'b1;
    @(posedge clk); #1;
    chk("b2b_out_valid_low", {511'd0, ov[0]}, 512'd0);
    chk("b2b_in_ready", {511'd0, ir[0]}, 512'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("b2b_accepted", {511'd0, ir[0]}, 512'd0);
    chk("b2b_busy", {511'd0, bz[0]}, 512'd1);
    drain();

    // Reset in round 7 aborts the block
    send(0, h_iv, m2, t2);
    repeat (14) @(posedge clk);
    #1; rst = 1'b1;
    sb_q.delete();
    #1;
    chk("abort_out_valid", {511'd0, ov[0]}, 512'd0);
    chk("abort_busy", {511'd0, bz[0]}, 512'd0);
    chk("abort_in_ready", {511'd0, ir[0]}, 512'd1);
    chk("abort_h_out", ho[0], '0);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    send(0, h_iv, m1, t1);
    drain();

    // G_PAR sweep on the counter vector
    send(1, h_iv, m2, t2);
    drain();
    send(2, h_iv, m2, t2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
